// File: rtl/jtag_scan_master_if.sv
// Command/response channel bundle for the JTAG scan master.
// master drives commands and consumes responses; slave is the scan engine.
interface jtag_scan_master_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(DATA_W + 1)
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_op_i;
    logic [LEN_W-1:0]  cmd_len_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_err_o;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_len_i, cmd_data_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_len_i, cmd_data_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/jtag_scan_master.sv
// JTAG initiator: walks the TAP from Run-Test/Idle for DR/IR scans and resets.
// Optional JTAG_SCAN_LOCK_EN adds lock_i, which rejects IR scans and TAP resets.
module jtag_scan_master #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = $clog2(DATA_W + 1),
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
`ifdef JTAG_SCAN_LOCK_EN
    input  logic lock_i,
`endif
    jtag_scan_master_if.slave bus,
    output logic tck_o,
    output logic tms_o,
    output logic tdi_o,
    input  logic tdo_i,
    output logic busy_o
);
    localparam int IW = (LEN_W > 3) ? LEN_W : 3;
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);
    localparam logic [1:0] OP_DR  = 2'd0;
    localparam logic [1:0] OP_IR  = 2'd1;
    localparam logic [1:0] OP_RST = 2'd2;

    typedef enum logic [2:0] {
        AUTO_RST, IDLE, PRE, SHIFT, POST, RSP
    } state_e;

    state_e            state_q, nst_d;
    logic [IW-1:0]     idx_q, nidx_d, last_d, pre_last_d;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        op_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] sh_q, mask_q, rsp_data_q;
    logic              tck_q, tms_q, tdi_q, rdy_q;
    logic              rsp_valid_q, err_q, busy_q;
    logic              tms_d, tdi_d, bad_d, rise_d, fall_d;

    assign rise_d = cnt_q == CW'(CLK_DIV - 1);
    assign fall_d = cnt_q == CW'(2 * CLK_DIV - 1);
    assign last_d = IW'(len_q) - IW'(1);

    function automatic logic tms_of(state_e s, logic [IW-1:0] k,
                                    logic [1:0] op, logic [IW-1:0] last);
        case (s)
            AUTO_RST: tms_of = k < IW'(5);
            PRE: begin
                if (op == OP_DR)      tms_of = k == '0;
                else if (op == OP_IR) tms_of = k < IW'(2);
                else                  tms_of = k < IW'(5);
            end
            SHIFT:    tms_of = k == last;
            POST:     tms_of = k == '0;
            default:  tms_of = 1'b0;
        endcase
    endfunction

    always_comb begin
        unique case (1'b1)
            (op_q == OP_DR): pre_last_d = IW'(2);
            (op_q == OP_IR): pre_last_d = IW'(3);
            default:         pre_last_d = IW'(5);
        endcase
    end

    always_comb begin
        bad_d = (bus.cmd_op_i == 2'd3)
              || (bus.cmd_op_i != OP_RST
                  && (bus.cmd_len_i == '0 || bus.cmd_len_i > MAX_LEN));
`ifdef JTAG_SCAN_LOCK_EN
        if (lock_i && (bus.cmd_op_i == OP_IR || bus.cmd_op_i == OP_RST))
            bad_d = 1'b1;
`endif
    end

    // Where the slot following the current one lands, and its TMS/TDI.
    always_comb begin
        nst_d  = state_q;
        nidx_d = idx_q + IW'(1);
        unique case (state_q)
            AUTO_RST: if (idx_q == IW'(5)) begin
                nst_d  = IDLE;
                nidx_d = '0;
            end
            PRE: if (idx_q == pre_last_d) begin
                nst_d  = (op_q == OP_RST) ? RSP : SHIFT;
                nidx_d = '0;
            end
            SHIFT: if (idx_q == last_d) begin
                nst_d  = POST;
                nidx_d = '0;
            end
            POST: if (idx_q == IW'(1)) begin
                nst_d  = RSP;
                nidx_d = '0;
            end
            default: ;
        endcase
        tms_d = tms_of(nst_d, nidx_d, op_q, last_d);
        tdi_d = (nst_d == SHIFT) ? sh_q[0] : 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= AUTO_RST;
            idx_q       <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            len_q       <= '0;
            sh_q        <= '0;
            mask_q      <= '0;
            rsp_data_q  <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rdy_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: if (bus.cmd_valid_i && rdy_q) begin
                    rdy_q      <= 1'b0;
                    busy_q     <= 1'b1;
                    op_q       <= bus.cmd_op_i;
                    len_q      <= bus.cmd_len_i;
                    sh_q       <= bus.cmd_data_i;
                    mask_q     <= DATA_W'(1);
                    rsp_data_q <= '0;
                    idx_q      <= '0;
                    cnt_q      <= '0;
                    err_q      <= bad_d;
                    if (bad_d) begin
                        state_q     <= RSP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        state_q <= PRE;
                        tms_q   <= 1'b1;
                    end
                end
                RSP: if (bus.rsp_ready_i) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                    rdy_q       <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (rise_d) begin
                        tck_q <= 1'b1;
                        if (state_q == SHIFT) begin
                            rsp_data_q <= rsp_data_q
                                        | (mask_q & {DATA_W{tdo_i}});
                            mask_q     <= mask_q << 1;
                        end
                    end
                    if (fall_d) begin
                        tck_q   <= 1'b0;
                        cnt_q   <= '0;
                        idx_q   <= nidx_d;
                        state_q <= nst_d;
                        tms_q   <= tms_d;
                        tdi_q   <= tdi_d;
                        if (nst_d == SHIFT) sh_q <= sh_q >> 1;
                        if (nst_d == IDLE) begin
                            rdy_q  <= 1'b1;
                            busy_q <= 1'b0;
                        end
                        if (nst_d == RSP) rsp_valid_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready_o = rdy_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = err_q;
    assign tck_o           = tck_q;
    assign tms_o           = tms_q;
    assign tdi_o           = tdi_q;
    assign busy_o          = busy_q;
endmodule

// File: tb/tb_jtag_scan_master.sv
// Randomized bench for jtag_scan_master against a slot-level TAP model.
// Observes every TCK rise and compares TMS/TDI, period and the response.
module tb_jtag_scan_master;
    localparam int DW = 32;
    localparam int LW = 6;
    localparam int CD = 2;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic tck, tms, tdi, tdo, busy;
    logic lock_i = 1'b0;
    int   tdo_mode = 0;

    always #5 clk = ~clk;

    jtag_scan_master_if #(.DATA_W(DW), .LEN_W(LW)) bif ();

    assign tdo = (tdo_mode == 0) ? tdi : (tdo_mode == 1) ? 1'b1 : ~tdi;

    jtag_scan_master #(.DATA_W(DW), .LEN_W(LW), .CLK_DIV(CD)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
`ifdef JTAG_SCAN_LOCK_EN
        .lock_i (lock_i),
`endif
        .bus    (bif.slave),
        .tck_o  (tck),
        .tms_o  (tms),
        .tdi_o  (tdi),
        .tdo_i  (tdo),
        .busy_o (busy)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit tck_prev = 1'b0;
    bit q_tms[$];
    bit q_tdi[$];
    int q_t[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tck && !tck_prev) begin
            q_tms.push_back(tms);
            q_tdi.push_back(tdi);
            q_t.push_back(cyc);
        end
        tck_prev = tck;
    end

    task automatic clear_q();
        q_tms.delete();
        q_tdi.delete();
        q_t.delete();
    endtask

    // ---- reference model: TAP walk expressed slot by slot ----
    function automatic int pre_len(int op);
        return (op == 1) ? 4 : 3;
    endfunction

    function automatic int n_slots(int op, int len);
        return (op == 2) ? 6 : pre_len(op) + len + 2;
    endfunction

    function automatic bit exp_tms(int op, int len, int k);
        int p;
        if (op == 2) return k < 5;
        p = pre_len(op);
        if (k < p) return (op == 1) ? (k < 2) : (k == 0);
        if (k < p + len) return k == p + len - 1;
        return k == p + len;
    endfunction

    function automatic bit exp_tdi(int op, int len, logic [31:0] d, int k);
        int p;
        if (op == 2) return 1'b0;
        p = pre_len(op);
        if (k >= p && k < p + len) return d[k-p];
        return 1'b0;
    endfunction

    function automatic int seq_errs(int op, int len, logic [31:0] d);
        int e;
        e = 0;
        if (q_tms.size() != n_slots(op, len)) return 1000 + q_tms.size();
        for (int k = 0; k < q_tms.size(); k++) begin
            if (q_tms[k] != exp_tms(op, len, k)) e++;
            if (q_tdi[k] != exp_tdi(op, len, d, k)) e++;
        end
        return e;
    endfunction

    function automatic int period_errs();
        int e;
        e = 0;
        for (int k = 1; k < q_t.size(); k++)
            if (q_t[k] - q_t[k-1] != 2 * CD) e++;
        return e;
    endfunction

    function automatic logic [31:0] exp_rsp(int len, logic [31:0] d, int mode);
        logic [63:0] m;
        m = (64'd1 << len) - 64'd1;
        if (mode == 0) return d & m[31:0];
        if (mode == 1) return m[31:0];
        return ~d & m[31:0];
    endfunction

    // ---- drivers (called at #1 after a rising edge) ----
    task automatic send_cmd(input int op, input int len,
                            input logic [31:0] d, output bit to);
        bif.cmd_op_i    = op[1:0];
        bif.cmd_len_i   = len[LW-1:0];
        bif.cmd_data_i  = d;
        bif.cmd_valid_i = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (bif.cmd_ready_o) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        if (!to) begin
            @(posedge clk); #1;
        end
        bif.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output int n, output bit to);
        n = 0;
        while (!bif.rsp_valid_o && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        to = !bif.rsp_valid_o;
    endtask

    task automatic wait_ready(output bit to);
        int n;
        n = 0;
        while (!bif.cmd_ready_o && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        to = !bif.cmd_ready_o;
    endtask

    task automatic handshake();
        bif.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bif.rsp_ready_i = 1'b0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        bit to;
        int e;
        rst_ni = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({tck, tms, tdi, bif.cmd_ready_o, bif.rsp_valid_o,
             bif.rsp_err_o, busy} !== 7'b0100001) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 0100001",
                     {tck, tms, tdi, bif.cmd_ready_o, bif.rsp_valid_o,
                      bif.rsp_err_o, busy});
        end
        n_checks++;
        if (bif.rsp_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rsp_data got %h want 0", bif.rsp_data_o);
        end
        clear_q();
        rst_ni = 1'b1;
        wait_ready(to);
        e = seq_errs(2, 0, 32'h0) + period_errs();
        n_checks++;
        if (to || e != 0) begin
            n_fail++;
            $display("FAIL auto_reset_seq timeout=%0d errs=%0d pulses=%0d want 6",
                     to, e, q_tms.size());
        end
        n_checks++;
        if ({bif.rsp_valid_o, busy, tck} !== 3'b000) begin
            n_fail++;
            $display("FAIL auto_reset_idle got %b want 000",
                     {bif.rsp_valid_o, busy, tck});
        end
    endtask

    task automatic test_dr_a5();
        bit to1, to2;
        int n, e;
        tdo_mode = 0;
        clear_q();
        send_cmd(0, 8, 32'hA5, to1);
        wait_rsp(n, to2);
        e = seq_errs(0, 8, 32'hA5) + period_errs();
        n_checks++;
        if (to1 || to2 || e != 0) begin
            n_fail++;
            $display("FAIL dr_a5_seq timeout=%0d/%0d errs=%0d want 0",
                     to1, to2, e);
        end
        n_checks++;
        if ({bif.rsp_err_o, bif.rsp_data_o} !== {1'b0, 32'hA5}) begin
            n_fail++;
            $display("FAIL dr_a5_rsp got err=%b data=%h want err=0 data=000000a5",
                     bif.rsp_err_o, bif.rsp_data_o);
        end
        handshake();
        n_checks++;
        if ({bif.rsp_valid_o, bif.cmd_ready_o, tck} !== 3'b010) begin
            n_fail++;
            $display("FAIL dr_a5_release got %b want 010",
                     {bif.rsp_valid_o, bif.cmd_ready_o, tck});
        end
    endtask

    task automatic test_ir();
        bit to1, to2;
        int n, e;
        tdo_mode = 1;
        clear_q();
        send_cmd(1, 5, 32'h11, to1);
        wait_rsp(n, to2);
        e = seq_errs(1, 5, 32'h11) + period_errs();
        n_checks++;
        if (to1 || to2 || e != 0) begin
            n_fail++;
            $display("FAIL ir_seq timeout=%0d/%0d errs=%0d want 0", to1, to2, e);
        end
        n_checks++;
        if ({bif.rsp_err_o, bif.rsp_data_o} !== {1'b0, 32'h1F}) begin
            n_fail++;
            $display("FAIL ir_rsp got err=%b data=%h want err=0 data=0000001f",
                     bif.rsp_err_o, bif.rsp_data_o);
        end
        handshake();
    endtask

    task automatic test_tap_reset();
        bit to1, to2;
        int n, e;
        tdo_mode = 1;
        clear_q();
        send_cmd(2, $urandom_range(0, 40), $urandom, to1);
        wait_rsp(n, to2);
        e = seq_errs(2, 0, 32'h0) + period_errs();
        n_checks++;
        if (to1 || to2 || e != 0) begin
            n_fail++;
            $display("FAIL tap_reset_seq timeout=%0d/%0d errs=%0d", to1, to2, e);
        end
        n_checks++;
        if ({bif.rsp_err_o, bif.rsp_data_o} !== 33'h0) begin
            n_fail++;
            $display("FAIL tap_reset_rsp got err=%b data=%h want 0",
                     bif.rsp_err_o, bif.rsp_data_o);
        end
        handshake();
    endtask

    task automatic test_errors();
        int ops[3] = '{0, 0, 3};
        int lens[3] = '{0, 33, 8};
        bit to1, to2;
        int n, hold_bad;
        logic [32:0] snap;
        for (int c = 0; c < 3; c++) begin
            clear_q();
            send_cmd(ops[c], lens[c], $urandom, to1);
            wait_rsp(n, to2);
            n_checks++;
            if (to1 || to2 || n != 0) begin
                n_fail++;
                $display("FAIL err%0d_latency got %0d cycles want 0 (timeout=%0d/%0d)",
                         c, n, to1, to2);
            end
            n_checks++;
            if ({bif.rsp_err_o, bif.rsp_data_o} !== {1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL err%0d_rsp got err=%b data=%h want err=1 data=0",
                         c, bif.rsp_err_o, bif.rsp_data_o);
            end
            snap = {bif.rsp_err_o, bif.rsp_data_o};
            hold_bad = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (!bif.rsp_valid_o || {bif.rsp_err_o, bif.rsp_data_o} != snap)
                    hold_bad++;
            end
            n_checks++;
            if (hold_bad != 0 || q_tms.size() != 0 || tck !== 1'b0) begin
                n_fail++;
                $display("FAIL err%0d_hold unstable=%0d tck_pulses=%0d want 0/0",
                         c, hold_bad, q_tms.size());
            end
            handshake();
        end
    endtask

    task automatic test_random();
        bit to1, to2;
        int n, e, op, len, mode, bad;
        logic [31:0] d;
        bad = 0;
        for (int it = 0; it < 12; it++) begin
            op = $urandom_range(0, 1);
            len = $urandom_range(1, 32);
            d = $urandom;
            mode = $urandom_range(0, 2);
            tdo_mode = mode;
            clear_q();
            send_cmd(op, len, d, to1);
            wait_rsp(n, to2);
            e = seq_errs(op, len, d) + period_errs();
            n_checks++;
            if (to1 || to2 || e != 0 || bif.rsp_err_o !== 1'b0
                || bif.rsp_data_o !== exp_rsp(len, d, mode)) begin
                n_fail++;
                bad++;
                $display("FAIL rand%0d op=%0d len=%0d mode=%0d errs=%0d data=%h want %h",
                         it, op, len, mode, e, bif.rsp_data_o,
                         exp_rsp(len, d, mode));
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        bit to1, to2;
        int n, acc, sz;
        logic [31:0] d;
        tdo_mode = 0;
        clear_q();
        send_cmd(0, 3, 32'h5, to1);
        wait_rsp(n, to2);
        sz = q_tms.size();
        bif.cmd_op_i = 2'd0;
        bif.cmd_len_i = 6'd4;
        bif.cmd_valid_i = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (bif.cmd_ready_o || !bif.rsp_valid_o) acc++;
            @(posedge clk); #1;
        end
        bif.cmd_valid_i = 1'b0;
        n_checks++;
        if (to1 || to2 || acc != 0 || q_tms.size() != sz) begin
            n_fail++;
            $display("FAIL backpressure ready_or_drop=%0d pulses %0d->%0d want 0",
                     acc, sz, q_tms.size());
        end
        handshake();
        d = $urandom;
        clear_q();
        send_cmd(0, 32, d, to1);
        wait_rsp(n, to2);
        n_checks++;
        if (to1 || to2 || bif.rsp_data_o !== d
            || seq_errs(0, 32, d) != 0) begin
            n_fail++;
            $display("FAIL back_to_back got %h want %h", bif.rsp_data_o, d);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        bit to;
        int n;
        tdo_mode = 0;
        clear_q();
        send_cmd(0, 32, $urandom, to);
        n = 0;
        while (q_tms.size() < 6 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (to || n >= 500 || {tck, tms, tdi, bif.rsp_valid_o,
             bif.cmd_ready_o, busy} !== 6'b010001
            || bif.rsp_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid got %b data=%h want 010001 data=0",
                     {tck, tms, tdi, bif.rsp_valid_o, bif.cmd_ready_o, busy},
                     bif.rsp_data_o);
        end
        @(posedge clk); #1;
        clear_q();
        rst_ni = 1'b1;
        wait_ready(to);
        n = seq_errs(2, 0, 32'h0) + period_errs();
        n_checks++;
        if (to || n != 0 || bif.rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_rerun timeout=%0d errs=%0d rsp_valid=%b",
                     to, n, bif.rsp_valid_o);
        end
    endtask

`ifdef JTAG_SCAN_LOCK_EN
    task automatic test_lock();
        bit to1, to2;
        int n;
        logic [31:0] d;
        lock_i = 1'b1;
        for (int op = 1; op <= 2; op++) begin
            clear_q();
            send_cmd(op, 5, 32'h3, to1);
            wait_rsp(n, to2);
            n_checks++;
            if (to1 || to2 || n != 0 || bif.rsp_err_o !== 1'b1
                || q_tms.size() != 0) begin
                n_fail++;
                $display("FAIL lock_op%0d err=%b lat=%0d pulses=%0d want 1/0/0",
                         op, bif.rsp_err_o, n, q_tms.size());
            end
            handshake();
        end
        d = $urandom;
        tdo_mode = 0;
        clear_q();
        send_cmd(0, 4, d, to1);
        wait_rsp(n, to2);
        n_checks++;
        if (to1 || to2 || bif.rsp_err_o !== 1'b0
            || bif.rsp_data_o !== exp_rsp(4, d, 0)
            || seq_errs(0, 4, d) != 0) begin
            n_fail++;
            $display("FAIL lock_dr got err=%b data=%h want 0/%h",
                     bif.rsp_err_o, bif.rsp_data_o, exp_rsp(4, d, 0));
        end
        handshake();
        lock_i = 1'b0;
    endtask
`endif

    initial begin
        bif.cmd_valid_i = 1'b0;
        bif.cmd_op_i    = 2'd0;
        bif.cmd_len_i   = '0;
        bif.cmd_data_i  = '0;
        bif.rsp_ready_i = 1'b0;
        test_reset();
        test_dr_a5();
        test_ir();
        test_tap_reset();
        test_errors();
        test_random();
        test_back_to_back();
`ifdef JTAG_SCAN_LOCK_EN
        test_lock();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- JTAG initiator that drives the TMS/TCK/TDI pins of a downstream TAP controller and samples its TDO.
- Accepts DR-scan, IR-scan and TAP-reset commands over a valid/ready interface, walks the TAP state machine from Run-Test/Idle, and returns the captured TDO bits on a valid/ready response channel.
- Used by on-chip debug/test logic to exercise the TAP block from the host side.

Parameters:
- DATA_W, 32, maximum scan length in bits; width of the command and response data.
- LEN_W, $clog2(DATA_W+1), width of the scan-length field.
- CLK_DIV, 2, number of clk_i cycles per TCK half-period; must be at least 1.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  0=DR scan, 1=IR scan, 2=TAP reset, 3=reserved
- cmd_len_i  in  LEN_W  number of bits to shift
- cmd_data_i  in  DATA_W  TDI bits, LSB shifted first
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_data_o  out  DATA_W  captured TDO bits, LSB first
- rsp_err_o  out  1  command rejected
- tck_o  out  1  JTAG TCK
- tms_o  out  1  JTAG TMS
- tdi_o  out  1  JTAG TDI
- tdo_i  in  1  JTAG TDO
- busy_o  out  1  sequence in progress

Behaviour:
- Interface: one clock, clk_i; reset is asynchronous, active-low, on rst_ni.
- Reset values: tck_o=0, tms_o=1, tdi_o=0, cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, busy_o=1.
- TCK slot: one TCK period is 2*CLK_DIV clk_i cycles.
  - TMS and TDI change only at the start of the low phase.
  - tck_o rises after CLK_DIV cycles; tdo_i is sampled in that same cycle.
  - tck_o falls after a further CLK_DIV cycles.
  - tck_o idles low between commands.
- Auto-reset: after rst_ni deasserts, the block issues 5 slots of TMS=1 then 1 slot of TMS=0, leaving the TAP in Run-Test/Idle. It then sets busy_o=0 and cmd_ready_o=1. No response is generated for the auto-reset.
- FSM states: AUTO_RST, IDLE, PRE (Select/Capture walk), SHIFT, POST (Exit1/Update/Idle), RSP.
- cmd_ready_o is 1 only in IDLE. On accept, op/len/data are latched and busy_o=1.
- DR scan TMS sequence: 1,0,0 | len shift slots with TMS=0, except the last shift slot which uses TMS=1 | 1,0. Total 5+len slots.
- IR scan TMS sequence: 1,1,0,0 | shift slots as for DR | 1,0. Total 6+len slots.
- TAP reset: TMS 1,1,1,1,1,0 (6 slots). Response has rsp_data_o=0 and rsp_err_o=0.
- Shift slot i (i=0..len-1): tdi_o=data[i]; the sampled tdo_i is stored in rsp bit i. Response bits at index len and above are 0. tdi_o=0 outside shift slots.
- Error check: op=3, or a scan with len=0 or len>DATA_W, produces no TCK activity. The block enters RSP on the next cycle with rsp_err_o=1 and rsp_data_o=0.
- RSP state: rsp_valid_o is held with stable data until rsp_ready_i. On the handshake cycle the block returns to IDLE, so cmd_ready_o=1 on the following cycle.
- Back-pressure: no new command is accepted while a response is pending.
- Reset mid-operation: all state returns to reset values immediately. The in-flight command and any pending response are discarded, and the auto-reset sequence reruns.

Optional Feature:
- JTAG_SCAN_LOCK_EN: when defined, adds input port lock_i (1 bit, sampled at command accept).
  - If lock_i=1, IR-scan and TAP-reset commands are rejected (rsp_err_o=1, no TCK activity).
  - DR scans still execute.
  - Auto-reset after rst_ni is never blocked.
- Without the macro: port absent, all ops execute.

Test Plan:
- Reset release, CLK_DIV=2 → exactly 6 TCK pulses with TMS 1,1,1,1,1,0, each period 4 clk_i; then cmd_ready_o=1, no rsp_valid_o.
- DR scan len=8, data=0xA5, tdo_i looped from tdi_o → TMS 1,0,0,0×7,1,1,0; TDI bits 1,0,1,0,0,1,0,1 in shift slots; rsp_data_o=0x000000A5, rsp_err_o=0.
- IR scan len=5, data=0x11, tdo_i tied 1 → 11 slots with TMS 1,1,0,0,0,0,0,0,1,1,0; rsp_data_o=0x1F.
- Errors: len=0, len=33 (DATA_W=32), op=3 → no TCK edge; rsp_err_o=1 one cycle after accept; rsp_valid_o holds for 10 cycles with rsp_ready_i=0.
- rst_ni asserted mid-shift of a 32-bit DR scan → tck_o=0, tms_o=1, rsp_valid_o=0 immediately; auto-reset reruns after release.
- With JTAG_SCAN_LOCK_EN and lock_i=1 → IR scan gets rsp_err_o=1 with no TCK; DR scan len=4 completes normally.
